meta_read_arb: RTL and testbench

META_READ_ARB -- requirements
Module: meta_read_arb

---
 rtl/meta_read_arb_pkg.sv | 16 +
 rtl/meta_read_arb_if.sv | 32 +++
 rtl/meta_read_arb_rr_arbiter.sv | 33 +++
 rtl/meta_read_arb.sv | 107 ++++++++++
 tb/tb_meta_read_arb.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/meta_read_arb_pkg.sv
// Shared types and default sizing for the metadata read arbiter.
// FSM state encoding lives here so the top and any bench agree on it.
package meta_arb_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int ADDR_W_DEF  = 8;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/meta_read_arb_if.sv
// Request/response and metadata-decoder signals of the read arbiter.
// slave = arbiter side; master = requesters plus decoder (the environment).
interface meta_read_arb_if
   import meta_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic                      rsp_err;
   logic                      meta_ren;
   logic [ADDR_W-1:0]         meta_raddr;
   logic [DATA_W-1:0]         meta_rdata;
   logic                      meta_rvalid;

   modport slave (
      input  req_valid, req_addr, meta_rdata, meta_rvalid,
      output req_ready, rsp_valid, rsp_data, rsp_err, meta_ren, meta_raddr
   );

   modport master (
      output req_valid, req_addr, meta_rdata, meta_rvalid,
      input  req_ready, rsp_valid, rsp_data, rsp_err, meta_ren, meta_raddr
   );

endinterface

// File: rtl/meta_read_arb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Zero latency; no requests gives an all-zero grant and index 0.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx
);

   // Scan farthest-to-nearest so the closest hit to ptr is the last write.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] ci;
      gnt  = '0;
      idx  = '0;
      cand = 0;
      ci   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = int'(ptr) + k;
         if (cand >= N) cand = cand - N;
         ci = IDX_W'(cand);
         if (req[ci]) begin
            gnt     = '0;
            gnt[ci] = 1'b1;
            idx     = ci;
         end
      end
   end

endmodule

// File: rtl/meta_read_arb.sv
// Round-robin arbiter giving NUM_REQ requesters one outstanding metadata read; accept->ren 1 cycle, rsp 1 cycle after rvalid.
// req_ready only in IDLE; a silent decoder is abandoned after TIMEOUT wait cycles with an error response.
module meta_read_arb
   import meta_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   meta_read_arb_if.slave    bus,
   output logic [31:0]       grant_cnt,
   output logic [15:0]       timeout_cnt
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WC_W  = $clog2(TIMEOUT) + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [IDX_W-1:0]  owner;
   } lat_t;

   state_t             state, state_nxt;
   lat_t               lat;
   logic [IDX_W-1:0]   ptr, gnt_idx;
   logic [NUM_REQ-1:0] gnt;
   logic [WC_W-1:0]    wait_cnt;
   logic               accept, rd_done, rd_tmo;

   rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req (bus.req_valid),
      .ptr (ptr),
      .gnt (gnt),
      .idx (gnt_idx)
   );

   assign accept  = (state == IDLE) && (|gnt);
   assign rd_done = (state == WAIT) && bus.meta_rvalid;
   // Data arriving on the last allowed cycle beats the timeout.
   assign rd_tmo  = (state == WAIT) && !bus.meta_rvalid && (wait_cnt == WC_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (rd_done || rd_tmo) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready  = (state == IDLE) ? gnt : '0;
      bus.meta_ren   = (state == ISSUE);
      bus.meta_raddr = lat.addr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat          <= '0;
         ptr          <= '0;
         wait_cnt     <= '0;
         grant_cnt    <= '0;
         timeout_cnt  <= '0;
         bus.rsp_valid <= '0;
         bus.rsp_data  <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         bus.rsp_valid <= '0;
         bus.rsp_err   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  lat.addr  <= bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
                  lat.owner <= gnt_idx;
                  ptr       <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
                  grant_cnt <= grant_cnt + 32'd1;
               end
            end
            ISSUE: wait_cnt <= '0;
            WAIT: begin
               if (rd_done) begin
                  bus.rsp_data             <= bus.meta_rdata;
                  bus.rsp_valid[lat.owner] <= 1'b1;
               end else if (rd_tmo) begin
                  bus.rsp_data             <= '0;
                  bus.rsp_err              <= 1'b1;
                  bus.rsp_valid[lat.owner] <= 1'b1;
                  if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
               end else begin
                  wait_cnt <= wait_cnt + WC_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_meta_read_arb.sv
// Directed bench for meta_read_arb: inputs change 2-3 time units after the rising edge,
// outputs are compared at least 1 unit after the last input change, well clear of the edge.
module tb_meta_read_arb;

   logic        clk;
   logic        rst;
   logic [31:0] grant_cnt;
   logic [15:0] timeout_cnt;
   int          checks;
   int          errors;

   meta_read_arb_if #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(32)) bus ();

   meta_read_arb #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .grant_cnt   (grant_cnt),
      .timeout_cnt (timeout_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (bus.meta_ren !== 1'b0) begin errors++; $display("FAIL reset_meta_ren: got %b want 0", bus.meta_ren); end
      checks++; if (bus.meta_raddr !== 8'h00) begin errors++; $display("FAIL reset_meta_raddr: got %h want 00", bus.meta_raddr); end
      checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid); end
      checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
      checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
      checks++; if (grant_cnt !== 32'd0) begin errors++; $display("FAIL reset_grant_cnt: got %0d want 0", grant_cnt); end
      checks++; if (timeout_cnt !== 16'd0) begin errors++; $display("FAIL reset_timeout_cnt: got %0d want 0", timeout_cnt); end
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_single();
      apply_reset();
      bus.req_addr  = 32'h0005_0000;
      bus.req_valid = 4'b0100;
      #1;
      checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_req_ready: got %b want 0100", bus.req_ready); end
      step();
      bus.req_valid = 4'b0000;
      #1;
      checks++; if (bus.meta_ren !== 1'b1) begin errors++; $display("FAIL single_meta_ren: got %b want 1", bus.meta_ren); end
      checks++; if (bus.meta_raddr !== 8'h05) begin errors++; $display("FAIL single_meta_raddr: got %h want 05", bus.meta_raddr); end
      checks++; if (grant_cnt !== 32'd1) begin errors++; $display("FAIL single_grant_cnt: got %0d want 1", grant_cnt); end
      step();
      bus.meta_rdata  = 32'hAAAA_0005;
      bus.meta_rvalid = 1'b1;
      #1;
      checks++; if (bus.meta_ren !== 1'b0) begin errors++; $display("FAIL single_ren_wait: got %b want 0", bus.meta_ren); end
      step();
      bus.meta_rvalid = 1'b0;
      #1;
      checks++; if (bus.rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid: got %b want 0100", bus.rsp_valid); end
      checks++; if (bus.rsp_data !== 32'hAAAA_0005) begin errors++; $display("FAIL single_rsp_data: got %h want aaaa0005", bus.rsp_data); end
      checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp_err: got %b want 0", bus.rsp_err); end
      step();
      checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_pulse: got %b want 0000", bus.rsp_valid); end
      checks++; if (bus.rsp_data !== 32'hAAAA_0005) begin errors++; $display("FAIL single_data_hold: got %h want aaaa0005", bus.rsp_data); end
      checks++; if (bus.meta_raddr !== 8'h05) begin errors++; $display("FAIL single_raddr_hold: got %h want 05", bus.meta_raddr); end
   endtask

   // Also exercises back-to-back: each new grant is visible in the same cycle as the previous response.
   task automatic test_round_robin();
      apply_reset();
      bus.req_addr  = 32'h1312_1110;
      bus.req_valid = 4'b1111;
      #1;
      for (int g = 0; g < 8; g++) begin
         logic [3:0]  exp_oh;
         logic [7:0]  exp_a;
         logic [31:0] exp_d;
         exp_oh = 4'(1 << (g % 4));
         exp_a  = 8'(8'h10 + (g % 4));
         exp_d  = 32'(g + 100);
         checks++; if (bus.req_ready !== exp_oh) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", g, bus.req_ready, exp_oh); end
         step();
         checks++; if (bus.meta_raddr !== exp_a) begin errors++; $display("FAIL rr_raddr%0d: got %h want %h", g, bus.meta_raddr, exp_a); end
         step();
         bus.meta_rdata  = exp_d;
         bus.meta_rvalid = 1'b1;
         #1;
         step();
         bus.meta_rvalid = 1'b0;
         #1;
         checks++; if (bus.rsp_valid !== exp_oh || bus.rsp_data !== exp_d) begin errors++; $display("FAIL rr_rsp%0d: got %b/%h want %b/%h", g, bus.rsp_valid, bus.rsp_data, exp_oh, exp_d); end
      end
      bus.req_valid = 4'b0000;
      step();
      checks++; if (grant_cnt !== 32'd8) begin errors++; $display("FAIL rr_grant_cnt: got %0d want 8", grant_cnt); end
   endtask

   task automatic test_timeout();
      apply_reset();
      bus.req_addr  = 32'h0000_2200;
      bus.req_valid = 4'b0010;
      #1;
      step();
      bus.req_valid = 4'b0000;
      step();
      bus.meta_rdata  = 32'h1234_5678;
      bus.meta_rvalid = 1'b1;
      step();
      bus.meta_rvalid = 1'b0;
      #1;
      checks++; if (bus.rsp_data !== 32'h1234_5678) begin errors++; $display("FAIL tmo_setup_data: got %h want 12345678", bus.rsp_data); end
      bus.req_addr  = 32'h0000_0033;
      bus.req_valid = 4'b0001;
      #1;
      checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL tmo_req_ready: got %b want 0001", bus.req_ready); end
      step();
      bus.req_valid = 4'b0000;
      step();
      for (int c = 0; c < 15; c++) step();
      checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL tmo_early: got %b want 0000", bus.rsp_valid); end
      step();
      checks++; if (bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL tmo_rsp_valid: got %b want 0001", bus.rsp_valid); end
      checks++; if (bus.rsp_err !== 1'b1) begin errors++; $display("FAIL tmo_rsp_err: got %b want 1", bus.rsp_err); end
      checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL tmo_rsp_data: got %h want 0", bus.rsp_data); end
      checks++; if (timeout_cnt !== 16'd1) begin errors++; $display("FAIL tmo_cnt: got %0d want 1", timeout_cnt); end
      checks++; if (grant_cnt !== 32'd2) begin errors++; $display("FAIL tmo_grant_cnt: got %0d want 2", grant_cnt); end
      bus.req_valid = 4'b0010;
      #1;
      checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL tmo_back_idle: got %b want 0010", bus.req_ready); end
      bus.req_valid = 4'b0000;
      step();
      checks++; if (bus.rsp_valid !== 4'b0000 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: got %b/%b want 0000/0", bus.rsp_valid, bus.rsp_err); end
   endtask

   task automatic test_race();
      apply_reset();
      bus.req_addr  = 32'h7E00_0000;
      bus.req_valid = 4'b1000;
      #1;
      step();
      bus.req_valid = 4'b0000;
      step();
      for (int c = 0; c < 15; c++) step();
      checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL race_early: got %b want 0000", bus.rsp_valid); end
      bus.meta_rdata  = 32'hCAFE_F00D;
      bus.meta_rvalid = 1'b1;
      step();
      bus.meta_rvalid = 1'b0;
      #1;
      checks++; if (bus.rsp_valid !== 4'b1000) begin errors++; $display("FAIL race_rsp_valid: got %b want 1000", bus.rsp_valid); end
      checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL race_rsp_err: got %b want 0", bus.rsp_err); end
      checks++; if (bus.rsp_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL race_rsp_data: got %h want cafef00d", bus.rsp_data); end
      checks++; if (timeout_cnt !== 16'd0) begin errors++; $display("FAIL race_timeout_cnt: got %0d want 0", timeout_cnt); end
   endtask

   task automatic test_reset_mid_wait();
      apply_reset();
      bus.req_addr  = 32'h0044_0000;
      bus.req_valid = 4'b0100;
      #1;
      step();
      bus.req_valid = 4'b0000;
      step();
      step();
      rst = 1'b1;
      #1;
      checks++; if (bus.meta_raddr !== 8'h00) begin errors++; $display("FAIL rstw_raddr: got %h want 00", bus.meta_raddr); end
      checks++; if (grant_cnt !== 32'd0) begin errors++; $display("FAIL rstw_grant_async: got %0d want 0", grant_cnt); end
      step();
      rst = 1'b0;
      step();
      step();
      bus.meta_rdata  = 32'hDEAD_0001;
      bus.meta_rvalid = 1'b1;
      step();
      bus.meta_rvalid = 1'b0;
      #1;
      checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL rstw_no_rsp: got %b want 0000", bus.rsp_valid); end
      checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL rstw_rsp_data: got %h want 0", bus.rsp_data); end
      checks++; if (grant_cnt !== 32'd0 || timeout_cnt !== 16'd0) begin errors++; $display("FAIL rstw_counters: got %0d/%0d want 0/0", grant_cnt, timeout_cnt); end
      bus.req_addr  = 32'h0000_2100;
      bus.req_valid = 4'b0010;
      #1;
      checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rstw_next_ready: got %b want 0010", bus.req_ready); end
      step();
      bus.req_valid = 4'b0000;
      #1;
      checks++; if (bus.meta_raddr !== 8'h21) begin errors++; $display("FAIL rstw_next_raddr: got %h want 21", bus.meta_raddr); end
      step();
      bus.meta_rdata  = 32'h0BAD_BEEF;
      bus.meta_rvalid = 1'b1;
      step();
      bus.meta_rvalid = 1'b0;
      #1;
      checks++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 32'h0BAD_BEEF) begin errors++; $display("FAIL rstw_next_rsp: got %b/%h want 0010/0badbeef", bus.rsp_valid, bus.rsp_data); end
      checks++; if (grant_cnt !== 32'd1) begin errors++; $display("FAIL rstw_next_grant_cnt: got %0d want 1", grant_cnt); end
   endtask

   task automatic test_spurious();
      bus.meta_rdata  = 32'h5555_5555;
      bus.meta_rvalid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++; if (bus.rsp_valid !== 4'b0000 || bus.rsp_data !== 32'h0BAD_BEEF || bus.meta_ren !== 1'b0) begin errors++; $display("FAIL spur_idle%0d: got %b/%h/%b want 0000/0badbeef/0", c, bus.rsp_valid, bus.rsp_data, bus.meta_ren); end
      end
      bus.req_addr  = 32'h0000_000F;
      bus.req_valid = 4'b0001;
      #1;
      step();
      bus.req_valid = 4'b0000;
      #1;
      checks++; if (bus.meta_ren !== 1'b1) begin errors++; $display("FAIL spur_issue_ren: got %b want 1", bus.meta_ren); end
      step();
      bus.meta_rvalid = 1'b0;
      #1;
      checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL spur_issue_ignored: got %b want 0000", bus.rsp_valid); end
      step();
      checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL spur_wait_quiet: got %b want 0000", bus.rsp_valid); end
      bus.meta_rdata  = 32'h0000_0077;
      bus.meta_rvalid = 1'b1;
      step();
      bus.meta_rvalid = 1'b0;
      #1;
      checks++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 32'h0000_0077) begin errors++; $display("FAIL spur_rsp: got %b/%h want 0001/00000077", bus.rsp_valid, bus.rsp_data); end
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      rst             = 1'b1;
      bus.req_valid   = '0;
      bus.req_addr    = '0;
      bus.meta_rdata  = '0;
      bus.meta_rvalid = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_race();
      test_reset_mid_wait();
      test_spurious();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
